my_ram_dma: RTL and testbench

//  Bus initiator for the 16K-word Hack RAM: drives addr/in/load of a my_ram_16k-style responder.

---
 rtl/my_ram_dma_pkg.sv | 11 +
 rtl/my_ram_dma.sv | 166 ++++++++++++++++
 tb/tb_my_ram_dma.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/my_ram_dma_pkg.sv
// my_ram_dma_pkg: shared types and default sizes for the Hack RAM DMA initiator.
//   state_e : FSM states (VFY is reachable only when MY_RAM_DMA_VERIFY_EN is defined)
//   mode_e  : command mode, COPY (src->dst) or FILL (constant->dst)
`timescale 1ns/1ps
package my_ram_dma_pkg;
    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {IDLE, RD, WR, VFY, FINISH} state_e;
    typedef enum logic {COPY = 1'b0, FILL = 1'b1} mode_e;
endpackage

// File: rtl/my_ram_dma.sv
// my_ram_dma: block COPY/FILL bus initiator for a my_ram_16k-style RAM.
// One command at a time; COPY takes RD+WR per word, FILL takes WR per word.
// Build option: MY_RAM_DMA_VERIFY_EN adds a VFY readback cycle after every WR and
// drives a sticky err flag on mismatch; undefined, err is tied low.
// Ports:
//   clk, reset            clock (shared with RAM), async active-high reset
//   start, mode           command strobe (sampled in IDLE) and 0=COPY / 1=FILL
//   src, dst, len         source base, destination base, word count (0..2**ADDR_W)
//   fill_val              FILL data word
//   busy, done, err       in-progress, one-cycle completion pulse, readback mismatch
//   ram_addr, ram_in      RAM address and write data
//   ram_load              RAM write enable (high only in WR)
//   ram_out               RAM read data, combinational on ram_addr
`timescale 1ns/1ps
module my_ram_dma
    import my_ram_dma_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    state_e             state, nxt;
    mode_e              mode_q;
    logic [ADDR_W-1:0]  src_ptr, dst_ptr;
    logic [ADDR_W:0]    remaining;
    logic [DATA_W-1:0]  fill_q, data_q;
    // Outputs hold their last driven value outside the states that own them.
    logic [ADDR_W-1:0]  addr_hold;
    logic [DATA_W-1:0]  in_hold;
    logic               advance;
    logic               last;
    state_e             word_next;

    assign last = (remaining == (ADDR_W+1)'(1));

    // State to enter once the current word is fully handled.
    always_comb begin
        word_next = RD;
        if (last)
            word_next = FINISH;
        else if (mode_q == FILL)
            word_next = WR;
    end

    always_comb begin
        nxt      = state;
        busy     = 1'b0;
        done     = 1'b0;
        ram_load = 1'b0;
        ram_addr = addr_hold;
        ram_in   = in_hold;
        advance  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len == '0)
                        nxt = FINISH;
                    else if (mode)
                        nxt = WR;
                    else
                        nxt = RD;
                end
            end
            RD: begin
                busy     = 1'b1;
                ram_addr = src_ptr;
                nxt      = WR;
            end
            WR: begin
                busy     = 1'b1;
                ram_addr = dst_ptr;
                ram_in   = (mode_q == FILL) ? fill_q : data_q;
                ram_load = 1'b1;
`ifdef MY_RAM_DMA_VERIFY_EN
                nxt      = VFY;
`else
                advance  = 1'b1;
                nxt      = word_next;
`endif
            end
            VFY: begin
`ifdef MY_RAM_DMA_VERIFY_EN
                // Pointers advance only after the readback so ram_addr still names
                // the word just written; ram_in (held) is the written value.
                busy     = 1'b1;
                ram_addr = dst_ptr;
                advance  = 1'b1;
                nxt      = word_next;
`else
                nxt      = IDLE;
`endif
            end
            FINISH: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

`ifdef MY_RAM_DMA_VERIFY_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mode_q    <= COPY;
            src_ptr   <= '0;
            dst_ptr   <= '0;
            remaining <= '0;
            fill_q    <= '0;
            data_q    <= '0;
            addr_hold <= '0;
            in_hold   <= '0;
`ifdef MY_RAM_DMA_VERIFY_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state     <= nxt;
            addr_hold <= ram_addr;
            in_hold   <= ram_in;
            if (state == IDLE && start) begin
                mode_q    <= mode_e'(mode);
                src_ptr   <= src;
                dst_ptr   <= dst;
                remaining <= len;
                fill_q    <= fill_val;
`ifdef MY_RAM_DMA_VERIFY_EN
                err_q     <= 1'b0;
`endif
            end
            if (state == RD)
                data_q <= ram_out;
            if (advance) begin
                src_ptr   <= src_ptr + 1'b1;
                dst_ptr   <= dst_ptr + 1'b1;
                remaining <= remaining - 1'b1;
            end
`ifdef MY_RAM_DMA_VERIFY_EN
            if (state == VFY && ram_out != in_hold)
                err_q <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_my_ram_dma.sv
// tb_my_ram_dma: self-checking bench for my_ram_dma with a behavioural 16K-word RAM
// (combinational read, write on rising clk) and a word-array reference model.
`timescale 1ns/1ps
module tb_my_ram_dma;
    localparam int AW = 14;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;
`ifdef MY_RAM_DMA_VERIFY_EN
    localparam int VF = 1;
`else
    localparam int VF = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src = '0, dst = '0;
    logic [AW:0]   len = '0;
    logic [DW-1:0] fill_val = '0;
    logic          busy, done, err, ram_load;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_in, ram_out;

    logic [DW-1:0] mem     [0:DEPTH-1];
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic          stuck_en = 1'b0;
    logic [AW-1:0] stuck_addr = '0;

    int errors = 0;
    int checks = 0;

    always #1 clk = ~clk;

    my_ram_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .fill_val(fill_val), .busy(busy), .done(done), .err(err),
        .ram_addr(ram_addr), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
    );

    // RAM with an optional stuck-at-1 bit 0 on one address (read side).
    assign ram_out = mem[ram_addr] | ((stuck_en && ram_addr == stuck_addr) ? 16'h0001 : 16'h0000);
    always @(posedge clk) if (ram_load) mem[ram_addr] <= ram_in;

    function automatic int exp_lat(input bit m, input int n);
        if (n == 0) return 1;
        return m ? (1 + VF) * n + 1 : (2 + VF) * n + 1;
    endfunction

    // Reference: words move in strictly ascending order, addresses wrap.
    task automatic ref_apply(input bit m, input int s, input int d, input int n, input logic [DW-1:0] v);
        for (int i = 0; i < n; i++)
            ref_mem[(d + i) % DEPTH] = m ? v : ref_mem[(s + i) % DEPTH];
    endtask

    task automatic mem_check(input string name);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d words differ, first @%0d got %h want %h",
                     name, bad, first, mem[first], ref_mem[first]);
        end
    endtask

    // Issue one command, wait for done (bounded), record latency, write activity, err trace.
    task automatic run_cmd(input bit m, input int s, input int d, input int n, input logic [DW-1:0] v,
                           input int restart, output int lat, output bit saw_load,
                           output logic [15:0] etrace);
        @(negedge clk);
        mode = m; src = AW'(s); dst = AW'(d); len = (AW+1)'(n); fill_val = v; start = 1'b1;
        lat = -1; saw_load = 1'b0; etrace = '0;
        for (int c = 1; c <= 70000; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (restart != 0 && c == restart) begin
                start = 1'b1; mode = 1'b1; dst = AW'(d) ^ 14'h2000; len = 15'd5; fill_val = 16'h5A5A;
            end
            if (c < 16) etrace[c] = err;
            if (ram_load) saw_load = 1'b1;
            if (done) begin lat = c; break; end
        end
        start = 1'b0;
        ref_apply(m, s, d, n, v);
    endtask

    task automatic check_lat(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, ram_load} !== 4'b0 || ram_addr !== '0 || ram_in !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b err=%b load=%b addr=%h in=%h want all 0",
                     busy, done, err, ram_load, ram_addr, ram_in);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_copy();
        int seen = 0;
        @(negedge clk);
        mode = 1'b0; src = 14'd200; dst = 14'd300; len = 15'd8; start = 1'b1;
        for (int c = 0; c < 100 && seen < 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (ram_load) seen++;
        end
        // Assert reset in the middle of the 4th WR, before its write edge.
        reset = 1'b1;
        #0.3;
        check_bit("mid_reset_busy", busy, 1'b0);
        check_bit("mid_reset_load", ram_load, 1'b0);
        ref_apply(1'b0, 200, 300, 3, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("post_reset_idle", busy, 1'b0);
        mem_check("mid_reset_mem");
    endtask

    task automatic test_fill();
        int lat; bit sl; logic [15:0] et;
        run_cmd(1'b1, 0, 100, 4, 16'hBEEF, 0, lat, sl, et);
        check_lat("fill", lat, exp_lat(1'b1, 4));
        check_bit("fill_err", err, 1'b0);
        checks++;
        if (mem[103] !== 16'hBEEF || mem[100] !== 16'hBEEF) begin
            errors++;
            $display("FAIL fill_words: got %h/%h want beef", mem[100], mem[103]);
        end
        mem_check("fill_mem");
    endtask

    task automatic test_copy();
        int lat; bit sl; logic [15:0] et;
        int d = 14'b10000110100111;
        mem[0] = 16'd2; mem[1] = 16'd9; mem[2] = 16'd1;
        ref_mem[0] = 16'd2; ref_mem[1] = 16'd9; ref_mem[2] = 16'd1;
        run_cmd(1'b0, 0, d, 3, '0, 0, lat, sl, et);
        check_lat("copy", lat, exp_lat(1'b0, 3));
        checks++;
        if (mem[d+1] !== 16'd9) begin
            errors++;
            $display("FAIL copy_word: got %h want 0009", mem[d+1]);
        end
        mem_check("copy_mem");
    endtask

    task automatic test_wrap();
        int lat; bit sl; logic [15:0] et;
        run_cmd(1'b1, 0, 14'h3FFE, 3, 16'd7, 0, lat, sl, et);
        check_lat("wrap", lat, exp_lat(1'b1, 3));
        checks++;
        if (mem[0] !== 16'd7) begin
            errors++;
            $display("FAIL wrap_word0: got %h want 0007", mem[0]);
        end
        mem_check("wrap_mem");
    endtask

    task automatic test_back_to_back();
        int lat; bit sl; logic [15:0] et;
        run_cmd(1'b1, 0, 900, 0, 16'h1111, 0, lat, sl, et);
        check_lat("len0", lat, 1);
        check_bit("len0_noload", sl, 1'b0);
        mem_check("len0_mem");
        // A second start mid-command must be ignored: one done pulse, then idle.
        run_cmd(1'b1, 0, 500, 6, 16'hC0DE, 2, lat, sl, et);
        check_lat("restart", lat, exp_lat(1'b1, 6));
        @(negedge clk);
        check_bit("done_one_cycle", done, 1'b0);
        repeat (3) @(negedge clk);
        check_bit("restart_idle", busy, 1'b0);
        mem_check("restart_mem");
    endtask

    task automatic test_random();
        int lat; bit sl; logic [15:0] et;
        for (int k = 0; k < 10; k++) begin
            bit m = 1'($urandom_range(0, 1));
            int s = $urandom_range(0, DEPTH - 1);
            int d = $urandom_range(0, DEPTH - 1);
            int n = $urandom_range(0, 40);
            logic [DW-1:0] v = DW'($urandom);
            run_cmd(m, s, d, n, v, 0, lat, sl, et);
            check_lat($sformatf("rand%0d", k), lat, exp_lat(m, n));
            mem_check($sformatf("rand%0d_mem", k));
        end
    endtask

    task automatic test_full();
        int lat; bit sl; logic [15:0] et;
        logic [DW-1:0] v = DW'($urandom);
        run_cmd(1'b1, 0, 1234, DEPTH, v, 0, lat, sl, et);
        check_lat("full", lat, exp_lat(1'b1, DEPTH));
        mem_check("full_mem");
    endtask

    task automatic test_verify();
`ifdef MY_RAM_DMA_VERIFY_EN
        int lat; bit sl; logic [15:0] et;
        stuck_en = 1'b1; stuck_addr = 14'd701;
        run_cmd(1'b1, 0, 700, 3, 16'h0000, 0, lat, sl, et);
        // word1: WR at cycle 3, VFY at 4, err visible from 5.
        check_bit("vfy_err_before", et[4], 1'b0);
        check_bit("vfy_err_after", et[5], 1'b1);
        check_bit("vfy_err_done", err, 1'b1);
        stuck_en = 1'b0;
        run_cmd(1'b1, 0, 800, 1, 16'h0F0F, 0, lat, sl, et);
        check_bit("vfy_err_clear", et[1], 1'b0);
        mem_check("vfy_mem");
`endif
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_reset_mid_copy();
        test_fill();
        test_copy();
        test_wrap();
        test_back_to_back();
        test_random();
        test_full();
        test_verify();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
